// File: rtl/mult_share_arb_pkg.sv
// Shared types and defaults for the multiplier-sharing arbiter.
// State encoding, default widths and watchdog counter sizing.
package mult_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RUN   = 2'd2
  } arb_state_e;

  localparam int M_BITS_DEF  = 12;
  localparam int N_BITS_DEF  = 8;
  localparam int NREQ_DEF    = 4;
  localparam int TIMEOUT_DEF = 64;

  function automatic int cnt_width(input int limit);
    return (limit < 2) ? 1 : $clog2(limit + 1);
  endfunction

  localparam int TO_CNT_W = cnt_width(TIMEOUT_DEF);

endpackage

// File: rtl/mult_share_arb_if.sv
// Bus between the arbiter (master) and the shared multiplier (slave).
interface mult_share_arb_if
  import mult_pkg::*;
#(
  parameter int M_BITS = M_BITS_DEF,
  parameter int N_BITS = N_BITS_DEF
) ();

  logic [M_BITS-1:0]        m_mpd;
  logic [N_BITS-1:0]        m_mpr;
  logic                     m_start;
  logic                     m_busy;
  logic [M_BITS+N_BITS-1:0] m_answer;

  modport master (
    output m_mpd, m_mpr, m_start,
    input  m_busy, m_answer
  );

  modport slave (
    input  m_mpd, m_mpr, m_start,
    output m_busy, m_answer
  );

endinterface

// File: rtl/mult_share_arb_rr_pick.sv
// Combinational rotating-priority picker: first set request at or after ptr,
// wrapping modulo NREQ; returns one-hot, index and a valid flag.
module mult_rr_pick #(
  parameter int NREQ  = 4,
  parameter int IDX_W = 2
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             valid
);

  logic [IDX_W-1:0] pos_s;

  // Scan from ptr upward; the first hit wins and later hits are masked.
  always_comb begin
    onehot = '0;
    idx    = '0;
    valid  = 1'b0;
    pos_s  = '0;
    for (int k = 0; k < NREQ; k++) begin
      pos_s = IDX_W'((int'(ptr) + k) % NREQ);
      if (!valid && req[pos_s]) begin
        valid         = 1'b1;
        idx           = pos_s;
        onehot[pos_s] = 1'b1;
      end else begin
        valid = valid;
      end
    end
  end

endmodule

// File: rtl/mult_share_arb.sv
// Round-robin sequencer sharing one multiplier among NREQ requesters.
// Optional watchdog on ISSUE/RUN enabled by defining MULT_ARB_TIMEOUT_EN.
module mult_share_arb
  import mult_pkg::*;
#(
  parameter int M_BITS  = M_BITS_DEF,
  parameter int N_BITS  = N_BITS_DEF,
  parameter int NREQ    = NREQ_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*M_BITS-1:0]   req_mpd,
  input  logic [NREQ*N_BITS-1:0]   req_mpr,
  output logic [NREQ-1:0]          gnt,
  output logic [NREQ-1:0]          done,
  output logic [M_BITS+N_BITS-1:0] result,
  output logic                     arb_busy,
  output logic                     err_timeout,
  mult_share_arb_if.master         mbus
);

  localparam int IDX_W = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int R_W   = M_BITS + N_BITS;

  if (NREQ < 2)    begin : g_bad_nreq    $error("NREQ must be at least 2");    end
  if (TIMEOUT < 1) begin : g_bad_timeout $error("TIMEOUT must be at least 1"); end

  arb_state_e       state_r, state_s;
  logic [IDX_W-1:0] ptr_r, idx_r, pick_idx_s, next_ptr_s;
  logic [NREQ-1:0]  pick_oh_s, idx_oh_s;
  logic             pick_vld_s;
  logic             grant_s, complete_s, abort_s;

  logic [NREQ-1:0]   gnt_r, gnt_s, done_r, done_s;
  logic [R_W-1:0]    result_r, result_s;
  logic [M_BITS-1:0] mpd_r;
  logic [N_BITS-1:0] mpr_r;
  logic              start_r, start_s, busy_r, busy_s, err_r, err_s;

  mult_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .ptr    (ptr_r),
    .onehot (pick_oh_s),
    .idx    (pick_idx_s),
    .valid  (pick_vld_s)
  );

  // A busy multiplier (e.g. still finishing work discarded by reset) blocks new grants.
  assign grant_s    = (state_r == ST_IDLE) && pick_vld_s && !mbus.m_busy;
  assign complete_s = (state_r == ST_RUN) && !mbus.m_busy && !abort_s;
  assign idx_oh_s   = {{(NREQ-1){1'b0}}, 1'b1} << idx_r;

`ifdef MULT_ARB_TIMEOUT_EN
  localparam int CNT_W = cnt_width(TIMEOUT);
  logic [CNT_W-1:0] wd_cnt_r;

  // Watchdog: restarts on every state change, counts while ISSUE/RUN persists.
  always_ff @(posedge clk) begin
    if (rst) begin
      wd_cnt_r <= '0;
    end else if (state_s != state_r) begin
      wd_cnt_r <= '0;
    end else if (state_r != ST_IDLE) begin
      wd_cnt_r <= wd_cnt_r + CNT_W'(1);
    end else begin
      wd_cnt_r <= '0;
    end
  end

  assign abort_s = (state_r != ST_IDLE) && (wd_cnt_r == CNT_W'(TIMEOUT - 1));
`else
  assign abort_s = 1'b0;
`endif

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (grant_s) state_s = ST_ISSUE;
        else         state_s = ST_IDLE;
      end
      ST_ISSUE: begin
        if (abort_s)           state_s = ST_IDLE;
        else if (mbus.m_busy)  state_s = ST_RUN;
        else                   state_s = ST_ISSUE;
      end
      ST_RUN: begin
        if (abort_s)           state_s = ST_IDLE;
        else if (!mbus.m_busy) state_s = ST_IDLE;
        else                   state_s = ST_RUN;
      end
      default: state_s = ST_IDLE;
    endcase
  end

  // FSM output logic: next values of the registered outputs.
  always_comb begin
    gnt_s      = '0;
    done_s     = '0;
    result_s   = result_r;
    err_s      = abort_s;
    start_s    = (state_s == ST_ISSUE);
    busy_s     = (state_s != ST_IDLE);
    next_ptr_s = ptr_r;
    if (grant_s) gnt_s = pick_oh_s;
    else         gnt_s = '0;
    if (complete_s || abort_s) begin
      done_s = idx_oh_s;
      if (idx_r == IDX_W'(NREQ - 1)) next_ptr_s = '0;
      else                            next_ptr_s = idx_r + IDX_W'(1);
    end else begin
      done_s = '0;
    end
    if (abort_s)         result_s = '0;
    else if (complete_s) result_s = mbus.m_answer;
    else                 result_s = result_r;
  end

  // Output, operand and pointer registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      gnt_r    <= '0;
      done_r   <= '0;
      result_r <= '0;
      mpd_r    <= '0;
      mpr_r    <= '0;
      start_r  <= 1'b0;
      busy_r   <= 1'b0;
      err_r    <= 1'b0;
      idx_r    <= '0;
      ptr_r    <= '0;
    end else begin
      gnt_r    <= gnt_s;
      done_r   <= done_s;
      result_r <= result_s;
      start_r  <= start_s;
      busy_r   <= busy_s;
      err_r    <= err_s;
      ptr_r    <= next_ptr_s;
      if (grant_s) begin
        mpd_r <= req_mpd[int'(pick_idx_s)*M_BITS +: M_BITS];
        mpr_r <= req_mpr[int'(pick_idx_s)*N_BITS +: N_BITS];
        idx_r <= pick_idx_s;
      end
    end
  end

  assign gnt          = gnt_r;
  assign done         = done_r;
  assign result       = result_r;
  assign arb_busy     = busy_r;
  assign err_timeout  = err_r;
  assign mbus.m_mpd   = mpd_r;
  assign mbus.m_mpr   = mpr_r;
  assign mbus.m_start = start_r;

endmodule

// File: tb/tb_mult_share_arb.sv
// Directed bench for mult_share_arb with a behavioural multiplier
// (busy rises 1 cycle after start, stays high 4 cycles; can be made to never respond).
module tb_mult_share_arb;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [3:0]  req = '0;
  logic [47:0] req_mpd = '0;
  logic [31:0] req_mpr = '0;
  logic [3:0]  gnt, done;
  logic [19:0] result;
  logic        arb_busy, err_timeout;

  int check_cnt = 0;
  int err_cnt   = 0;

  mult_share_arb_if #(.M_BITS(12), .N_BITS(8)) mbus ();

  mult_share_arb dut (
    .clk         (clk),
    .rst         (rst),
    .req         (req),
    .req_mpd     (req_mpd),
    .req_mpr     (req_mpr),
    .gnt         (gnt),
    .done        (done),
    .result      (result),
    .arb_busy    (arb_busy),
    .err_timeout (err_timeout),
    .mbus        (mbus)
  );

  always #5 clk = ~clk;

  // Multiplier model (not reset by the arbiter's reset).
  logic        model_dead = 1'b0;
  int          mdl_cnt    = 0;
  logic [19:0] mdl_ans    = '0;

  function automatic logic [19:0] smul(input logic [11:0] a, input logic [7:0] b);
    logic signed [19:0] sa, sb;
    sa = $signed({{8{a[11]}}, a});
    sb = $signed({{12{b[7]}}, b});
    return sa * sb;
  endfunction

  always @(posedge clk) begin
    if (mdl_cnt != 0) begin
      mdl_cnt <= mdl_cnt - 1;
    end else if (mbus.m_start && !model_dead) begin
      mdl_cnt <= 4;
      mdl_ans <= smul(mbus.m_mpd, mbus.m_mpr);
    end
  end
  assign mbus.m_busy   = (mdl_cnt != 0);
  assign mbus.m_answer = mdl_ans;

  // Event logs.
  logic [3:0]  gnt_log[$];
  logic [3:0]  done_log[$];
  logic [19:0] res_log[$];
  int          multi_gnt = 0;

  always @(negedge clk) begin
    if (gnt != 4'd0) gnt_log.push_back(gnt);
    if (done != 4'd0) begin
      done_log.push_back(done);
      res_log.push_back(result);
    end
    if ($countones(gnt) > 1) multi_gnt++;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    check_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req = 4'd0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic set_op(input int i, input logic [11:0] a, input logic [7:0] b);
    req_mpd[i*12 +: 12] = a;
    req_mpr[i*8 +: 8]   = b;
  endtask

  task automatic wait_gnt(input int limit, output logic [3:0] g, output int lat);
    g = 4'd0;
    lat = 0;
    for (int i = 1; i <= limit; i++) begin
      tick();
      if (gnt != 4'd0) begin
        g = gnt;
        lat = i;
        return;
      end
    end
  endtask

  task automatic wait_done(input int limit, output logic [3:0] d, output logic [19:0] r);
    d = 4'd0;
    r = '0;
    for (int i = 0; i < limit; i++) begin
      tick();
      if (done != 4'd0) begin
        d = done;
        r = result;
        return;
      end
    end
  endtask

  logic [3:0]  g, d;
  logic [19:0] r;
  int          lat, cnt, bad;
  logic [3:0]  exp_seq[4];
  logic [19:0] exp_res[4];

  initial begin
    // 1: reset values, then a single transaction
    do_reset();
    check_val("rst_gnt", gnt, 4'd0);
    check_val("rst_done", done, 4'd0);
    check_val("rst_result", result, 20'd0);
    check_val("rst_mpd", mbus.m_mpd, 12'd0);
    check_val("rst_start", mbus.m_start, 1'b0);
    check_val("rst_busy", arb_busy, 1'b0);
    check_val("rst_err", err_timeout, 1'b0);

    set_op(0, 12'hF00, 8'hF0);
    req = 4'b0001;
    wait_gnt(5, g, lat);
    check_val("t1_gnt", g, 4'b0001);
    check_val("t1_lat", lat, 1);
    check_val("t1_mpd", mbus.m_mpd, 12'hF00);
    check_val("t1_mpr", mbus.m_mpr, 8'hF0);
    check_val("t1_start", mbus.m_start, 1'b1);
    check_val("t1_arb_busy", arb_busy, 1'b1);
    req = 4'd0;
    tick();
    check_val("t1_gnt_pulse", gnt, 4'd0);
    wait_done(20, d, r);
    check_val("t1_done", d, 4'b0001);
    check_val("t1_result", r, 20'h01000);
    tick();
    check_val("t1_done_pulse", done, 4'd0);
    check_val("t1_idle", arb_busy, 1'b0);

    // 2: all four from reset -> 0,1,2,3
    do_reset();
    gnt_log.delete(); done_log.delete(); res_log.delete(); multi_gnt = 0;
    set_op(0, 12'h003, 8'h05);
    set_op(1, 12'hFFF, 8'h07);
    set_op(2, 12'h7FF, 8'h80);
    set_op(3, 12'h800, 8'h80);
    exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    exp_res = '{20'h0000F, 20'hFFFF9, 20'hC0080, 20'h40000};
    req = 4'b1111;
    for (int c = 0; c < 200 && done_log.size() < 4; c++) begin
      tick();
      req = req & ~gnt;
    end
    tick();
    check_val("t2_ngnt", gnt_log.size(), 4);
    check_val("t2_ndone", done_log.size(), 4);
    check_val("t2_multi", multi_gnt, 0);
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check_val($sformatf("t2_gnt%0d", i), gnt_log[i], exp_seq[i]);
    for (int i = 0; i < 4 && i < done_log.size(); i++) begin
      check_val($sformatf("t2_done%0d", i), done_log[i], exp_seq[i]);
      check_val($sformatf("t2_res%0d", i), res_log[i], exp_res[i]);
    end

    // 3: req[0] and req[2] held -> 0,2,0,2
    gnt_log.delete(); done_log.delete(); res_log.delete();
    req = 4'b0101;
    for (int c = 0; c < 200 && gnt_log.size() < 4; c++) tick();
    req = 4'd0;
    for (int c = 0; c < 40 && arb_busy; c++) tick();
    tick();
    check_val("t3_ngnt", gnt_log.size(), 4);
    exp_seq = '{4'b0001, 4'b0100, 4'b0001, 4'b0100};
    for (int i = 0; i < 4 && i < gnt_log.size(); i++)
      check_val($sformatf("t3_gnt%0d", i), gnt_log[i], exp_seq[i]);
    check_val("t3_ndone", done_log.size(), 4);

    // 4: reset during RUN
    set_op(1, 12'h010, 8'h10);
    req = 4'b0010;
    wait_gnt(5, g, lat);
    check_val("t4_gnt", g, 4'b0010);
    req = 4'd0;
    cnt = 0;
    while (cnt < 20 && mbus.m_start) begin tick(); cnt++; end
    check_val("t4_in_run", {arb_busy, mbus.m_busy}, 2'b11);
    gnt_log.delete(); done_log.delete(); res_log.delete();
    set_op(0, 12'h002, 8'hFD);
    req = 4'b0001;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_val("t4_rst_outs", {gnt, done, mbus.m_start, arb_busy, err_timeout}, 11'd0);
    check_val("t4_rst_result", result, 20'd0);
    check_val("t4_rst_mpd", mbus.m_mpd, 12'd0);
    check_val("t4_still_busy", mbus.m_busy, 1'b1);
    bad = 0;
    cnt = 0;
    while (cnt < 20 && mbus.m_busy) begin
      tick();
      cnt++;
      if (gnt != 4'd0 && mbus.m_busy) bad++;
    end
    check_val("t4_gnt_while_busy", bad, 0);
    wait_gnt(3, g, lat);
    check_val("t4_gnt_after", g, 4'b0001);
    req = 4'd0;
    wait_done(20, d, r);
    check_val("t4_done", d, 4'b0001);
    check_val("t4_result", r, 20'hFFFFA);
    check_val("t4_no_stale_done", done_log.size(), 1);

    // 5: multiplier never answers
    do_reset();
    model_dead = 1'b1;
    done_log.delete();
    set_op(2, 12'h055, 8'h03);
    req = 4'b0100;
    wait_gnt(5, g, lat);
    check_val("t5_gnt", g, 4'b0100);
    req = 4'd0;
`ifdef MULT_ARB_TIMEOUT_EN
    cnt = 0;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (err_timeout) begin cnt = k; break; end
    end
    check_val("t5_timeout_at", cnt, 64);
    check_val("t5_done", done, 4'b0100);
    check_val("t5_result", result, 20'd0);
    check_val("t5_idle", arb_busy, 1'b0);
    tick();
    check_val("t5_err_pulse", err_timeout, 1'b0);
`else
    bad = 0;
    for (int k = 0; k < 80; k++) begin
      tick();
      if (!mbus.m_start || err_timeout) bad++;
    end
    check_val("t5_hold_issue", bad, 0);
    check_val("t5_busy", arb_busy, 1'b1);
    check_val("t5_no_done", done_log.size(), 0);
`endif
    model_dead = 1'b0;

    // 6: req[1] dropped right after its grant
    do_reset();
    set_op(1, 12'h123, 8'hFE);
    req = 4'b0010;
    wait_gnt(5, g, lat);
    check_val("t6_gnt", g, 4'b0010);
    req = 4'd0;
    wait_done(20, d, r);
    check_val("t6_done", d, 4'b0010);
    check_val("t6_result", r, 20'hFFDBA);

    $display("Simulation finished: %0d checks, %0d errors", check_cnt, err_cnt);
    $finish;
  end

endmodule
